// File: rtl/fp32_adder_tree_8_feeder.sv
// Stream-to-vector operand collector feeding the 8-input FP32 adder tree.
// Optional macro FP32_FEEDER_NEG_ZERO_PAD_EN selects -0 instead of +0 for padded lanes.
module fp32_adder_tree_8_feeder #(
    parameter int NUM_LANES = 8,
    parameter int FP_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FP_WIDTH-1:0]           in_data,
    input  logic                          in_last,
    input  logic                          cfg_denorm_to_zero_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_LANES*FP_WIDTH-1:0] out_flat,
    output logic [3:0]                    out_count,
    output logic                          out_denorm_to_zero_en
);
    // state   | meaning
    // FILLING | collecting operands, in_ready = 1
    // FULL    | closed group parked in the fill buffer, waiting for the output register
    typedef enum logic {FILLING, FULL} state_t;

    localparam int CW = $clog2(NUM_LANES);
`ifdef FP32_FEEDER_NEG_ZERO_PAD_EN
    localparam logic [FP_WIDTH-1:0] PAD = FP_WIDTH'(32'h8000_0000);
`else
    localparam logic [FP_WIDTH-1:0] PAD = FP_WIDTH'(32'h0000_0000);
`endif

    state_t                         state, state_next;
    logic [FP_WIDTH-1:0]            lanes [NUM_LANES];
    logic [CW-1:0]                  cnt;
    logic                           grp_dte;
    logic                           acc, close, xfer, reg_free;
    logic [NUM_LANES*FP_WIDTH-1:0]  merged, buffered;
    logic                           merged_dte;

    assign in_ready   = (state == FILLING);
    assign acc        = in_valid && in_ready;
    assign close      = acc && (in_last || cnt == CW'(NUM_LANES - 1));
    assign xfer       = out_valid && out_ready;
    assign reg_free   = !out_valid || xfer;
    assign merged_dte = (cnt == '0) ? cfg_denorm_to_zero_en : grp_dte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FILLING;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILLING: if (close && !reg_free) state_next = FULL;
            FULL:    if (xfer)               state_next = FILLING;
            default: state_next = FILLING;
        endcase
    end

    // merged: closing operand bypasses the buffer; buffered: group parked in FULL
    always_comb begin
        merged   = '0;
        buffered = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (i < int'(cnt))       merged[i*FP_WIDTH +: FP_WIDTH] = lanes[i];
            else if (i == int'(cnt)) merged[i*FP_WIDTH +: FP_WIDTH] = in_data;
            else                     merged[i*FP_WIDTH +: FP_WIDTH] = PAD;
            buffered[i*FP_WIDTH +: FP_WIDTH] = (i <= int'(cnt)) ? lanes[i] : PAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LANES; i++) lanes[i] <= '0;
            cnt                   <= '0;
            grp_dte               <= 1'b0;
            out_valid             <= 1'b0;
            out_flat              <= '0;
            out_count             <= '0;
            out_denorm_to_zero_en <= 1'b0;
        end else begin
            if (acc && !(close && reg_free)) begin
                lanes[cnt] <= in_data;
                if (cnt == '0) grp_dte <= cfg_denorm_to_zero_en;
            end
            if (close && reg_free) begin
                out_flat              <= merged;
                out_count             <= 4'(cnt) + 4'd1;
                out_denorm_to_zero_en <= merged_dte;
                out_valid             <= 1'b1;
                cnt                   <= '0;
            end else if (state == FULL && xfer) begin
                // cnt still holds the closing lane index of the parked group
                out_flat              <= buffered;
                out_count             <= 4'(cnt) + 4'd1;
                out_denorm_to_zero_en <= grp_dte;
                out_valid             <= 1'b1;
                cnt                   <= '0;
            end else begin
                if (acc && !close) cnt <= cnt + CW'(1);
                if (xfer)          out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp32_adder_tree_8_feeder.sv
// Bench for fp32_adder_tree_8_feeder: directed scenarios plus random traffic
// checked every cycle against a queue-based group model.
module tb_fp32_adder_tree_8_feeder;
`ifdef FP32_FEEDER_NEG_ZERO_PAD_EN
    localparam logic [31:0] PAD = 32'h8000_0000;
`else
    localparam logic [31:0] PAD = 32'h0000_0000;
`endif

    logic         clk = 0;
    logic         rst_n = 0;
    logic         in_valid = 0;
    logic         in_ready;
    logic [31:0]  in_data = 0;
    logic         in_last = 0;
    logic         cfg = 0;
    logic         out_valid;
    logic         out_ready = 0;
    logic [255:0] out_flat;
    logic [3:0]   out_count;
    logic         out_dte;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [255:0] flat;
        logic [3:0]   count;
        logic         dte;
    } vec_t;

    vec_t        exp_q[$];
    logic [31:0] grp[$];
    logic        grp_dte;

    logic [31:0] ones [8] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                              32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};

    fp32_adder_tree_8_feeder dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_data               (in_data),
        .in_last               (in_last),
        .cfg_denorm_to_zero_en (cfg),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_flat              (out_flat),
        .out_count             (out_count),
        .out_denorm_to_zero_en (out_dte)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] lane(input logic [255:0] v, input int i);
        return v[i*32 +: 32];
    endfunction

    // Model: operands observed on input transfers form groups; closed groups queue
    // up until an output transfer retires them.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            grp.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                vec_t v;
                if (grp.size() == 0) grp_dte = cfg;
                grp.push_back(in_data);
                if (in_last || grp.size() == 8) begin
                    v.flat = {8{PAD}};
                    for (int i = 0; i < grp.size(); i++) v.flat[i*32 +: 32] = grp[i];
                    v.count = 4'(grp.size());
                    v.dte   = grp_dte;
                    exp_q.push_back(v);
                    grp.delete();
                end
            end
        end
    end

    // At most one vector in the register plus one parked group; outputs must
    // show the oldest pending vector every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 256'(out_valid), 256'(exp_q.size() > 0));
            chk("in_ready", 256'(in_ready), 256'(exp_q.size() < 2));
            if (out_valid && exp_q.size() > 0) begin
                chk("out_flat", out_flat, exp_q[0].flat);
                chk("out_count", 256'(out_count), 256'(exp_q[0].count));
                chk("out_dte", 256'(out_dte), 256'(exp_q[0].dte));
            end
        end
    end

    // Called and returns at a negedge; leaves in_valid asserted for back-to-back sends.
    task automatic send(input logic [31:0] d, input logic last, input logic c);
        int n;
        in_valid = 1; in_data = d; in_last = last; cfg = c;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_last = 0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        cycles(2);
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_flat", out_flat, 256'(0));
        chk("rst_out_count", 256'(out_count), 256'(0));
        chk("rst_out_dte", 256'(out_dte), 256'(0));
        rst_n = 1;
        cycles(1);

        // full group of 1.0..8.0
        out_ready = 1;
        for (int i = 0; i < 8; i++) send(ones[i], 1'b0, 1'b0);
        chk("full_valid", 256'(out_valid), 256'(1));
        chk("full_count", 256'(out_count), 256'(8));
        chk("full_lane0", 256'(lane(out_flat, 0)), 256'(32'h3F80_0000));
        chk("full_lane7", 256'(lane(out_flat, 7)), 256'(32'h4100_0000));
        idle();
        cycles(2);

        // short group 1.0, 2.0, 3.0
        for (int i = 0; i < 3; i++) send(ones[i], i == 2, 1'b0);
        chk("short_count", 256'(out_count), 256'(3));
        chk("short_lane2", 256'(lane(out_flat, 2)), 256'(32'h4040_0000));
        chk("short_lane3", 256'(lane(out_flat, 3)), 256'(PAD));
        chk("short_lane7", 256'(lane(out_flat, 7)), 256'(PAD));
        idle();
        cycles(2);

        // backpressure: 16 operands with the output stalled
        out_ready = 0;
        for (int i = 0; i < 16; i++) send(32'h1000 + 32'(i), 1'b0, 1'b0);
        idle();
        chk("bp_in_ready_low", 256'(in_ready), 256'(0));
        chk("bp_v1_lane0", 256'(lane(out_flat, 0)), 256'(32'h1000));
        cycles(3);
        chk("bp_v1_hold_lane7", 256'(lane(out_flat, 7)), 256'(32'h1007));
        out_ready = 1;
        cycles(1);
        out_ready = 0;
        chk("bp_v2_lane0", 256'(lane(out_flat, 0)), 256'(32'h1008));
        chk("bp_v2_count", 256'(out_count), 256'(8));
        chk("bp_in_ready_back", 256'(in_ready), 256'(1));
        out_ready = 1;
        cycles(2);

        // reset mid-group
        for (int i = 0; i < 5; i++) send(32'h2000 + 32'(i), 1'b0, 1'b0);
        idle();
        rst_n = 0;
        cycles(1);
        rst_n = 1;
        chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
        cycles(1);
        for (int i = 0; i < 8; i++) send(32'h3000 + 32'(i), 1'b0, 1'b0);
        chk("mid_rst_count", 256'(out_count), 256'(8));
        chk("mid_rst_lane0", 256'(lane(out_flat, 0)), 256'(32'h3000));
        idle();
        cycles(2);

        // two -0 operands
        send(32'h8000_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 1'b1, 1'b0);
        chk("negz_count", 256'(out_count), 256'(2));
        chk("negz_lane1", 256'(lane(out_flat, 1)), 256'(32'h8000_0000));
        chk("negz_lane2", 256'(lane(out_flat, 2)), 256'(PAD));
        chk("negz_lane7", 256'(lane(out_flat, 7)), 256'(PAD));
        idle();
        cycles(2);

        // cfg sampled on lane 0, NaN passes bit-exact
        send(ones[0], 1'b0, 1'b1);
        for (int i = 1; i < 6; i++) send((i == 4) ? 32'h7FC0_0000 : ones[i], i == 5, 1'b0);
        chk("cfg_dte", 256'(out_dte), 256'(1));
        chk("cfg_nan_lane4", 256'(lane(out_flat, 4)), 256'(32'h7FC0_0000));
        chk("cfg_count", 256'(out_count), 256'(6));
        idle();
        cycles(2);

        // random traffic with phases of light and heavy backpressure
        for (int c = 0; c < 4000; c++) begin
            int sel;
            in_valid = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0:       in_data = 32'h7FC0_0000;
                1:       in_data = 32'h8000_0000;
                2:       in_data = 32'h0000_0001;
                default: in_data = $urandom;
            endcase
            in_last = ($urandom_range(0, 4) == 0);
            cfg     = 1'($urandom_range(0, 1));
            if ((c / 500) % 2 == 0) out_ready = ($urandom_range(0, 3) != 0);
            else                    out_ready = ($urandom_range(0, 4) == 0);
            if (c == 2345) begin
                rst_n = 0;
                cycles(1);
                rst_n = 1;
            end
            @(negedge clk);
        end
        idle();
        out_ready = 1;
        cycles(20);
        chk("drain_empty", 256'(out_valid), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
